masked_gf16_inverter_stream: RTL

Valid/ready-streamed, d-share DOM-masked GF(2^4) inverter with stall support and asynchronous reset. It is the successor to the free-running pipelined inverter and sits in the middle of the masked AES S-box tower-field datapath, between the GF(2^8)→GF(2^4) reduction and the GF(2^4) output multipliers. Unlike its predecessor it tracks per-stage validity, tolerates downstream backpressure, and consumes fresh randomness only on pipeline advance.

---
 rtl/masked_inv_pkg.sv | 42 ++++
 rtl/masked_gf16_inverter_stream_dom_gf4_mul_en.sv | 58 +++++
 rtl/masked_gf16_inverter_stream.sv | 96 +++++++++
 3 files changed

// File: rtl/masked_inv_pkg.sv
// Shared GF(2^2) arithmetic and share-slicing helpers for the masked GF(2^4) inverter.
// GF(2^2) uses polynomial basis w^2 = w + 1; GF(2^4) uses the normal basis {Y^4, Y}
// with Y^2 + Y + w = 0, so the inverse of {A, B} is {B*E, A*E}, E = (nu*(A^B)^2 ^ A*B)^-1.
package masked_inv_pkg;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // nu * t^2 with nu = w collapses to a bit swap in this basis
    function automatic logic [1:0] gf4_sq_sc(input logic [1:0] t);
        return {t[0], t[1]};
    endfunction

    // squaring is the GF(2^2) inverse and is linear, so it is applied share-wise
    function automatic logic [1:0] gf4_sq(input logic [1:0] t);
        return {t[1], t[1] ^ t[0]};
    endfunction

    // one 2-bit mask per unordered share pair
    function automatic int rnd_width(input int shares);
        return shares * (shares - 1);
    endfunction

    // index of unordered pair (i, j), i < j
    function automatic int pair_idx(input int i, input int j, input int shares);
        int p;
        p = 0;
        for (int k = 0; k < i; k++) p = p + shares - 1 - k;
        return p + j - i - 1;
    endfunction

    function automatic logic [1:0] nib_hi(input logic [3:0] n);
        return n[3:2];
    endfunction

    function automatic logic [1:0] nib_lo(input logic [3:0] n);
        return n[1:0];
    endfunction

endpackage

// File: rtl/masked_gf16_inverter_stream_dom_gf4_mul_en.sv
// One DOM GF(2^2) multiplier stage with enable and bubble clear.
// Registers hold the inner-domain (diagonal) and masked cross-domain terms;
// the output is the share-wise XOR compression of those registers.
module dom_gf4_mul_en
    import masked_inv_pkg::*;
#(
    parameter int SHARES = 2,
    parameter bit SQSC   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clr,
    input  logic [2*SHARES-1:0]          x,
    input  logic [2*SHARES-1:0]          y,
    input  logic [rnd_width(SHARES)-1:0] z,
    output logic [2*SHARES-1:0]          q
);

    localparam int TW = 2 * SHARES * SHARES;

    logic [TW-1:0] term_d, term_q;

    // next partial products: diagonal stays in its domain, cross terms get the pair mask
    always_comb begin
        term_d = term_q;
        if (en) begin
            for (int i = 0; i < SHARES; i++) begin
                for (int j = 0; j < SHARES; j++) begin
                    if (clr) begin
                        term_d[2*(i*SHARES+j) +: 2] = 2'b00;
                    end else if (i == j) begin
                        term_d[2*(i*SHARES+j) +: 2] = gf4_mul(x[2*i +: 2], y[2*i +: 2])
                            ^ (SQSC ? gf4_sq_sc(x[2*i +: 2] ^ y[2*i +: 2]) : 2'b00);
                    end else begin
                        term_d[2*(i*SHARES+j) +: 2] = gf4_mul(x[2*i +: 2], y[2*j +: 2])
                            ^ z[2*((i < j) ? pair_idx(i, j, SHARES) : pair_idx(j, i, SHARES)) +: 2];
                    end
                end
            end
        end
    end

    // term registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) term_q <= '0;
        else        term_q <= term_d;
    end

    // compression of each output domain
    always_comb begin
        q = '0;
        for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
                q[2*i +: 2] = q[2*i +: 2] ^ term_q[2*(i*SHARES+j) +: 2];
    end

endmodule

// File: rtl/masked_gf16_inverter_stream.sv
// Valid/ready streamed d-share DOM-masked GF(2^4) inverter, two register stages.
// Optional macro MASKED_INV_BUBBLE_CLEAR_EN: stage registers load zero shares for bubbles.
module masked_gf16_inverter_stream
    import masked_inv_pkg::*;
#(
    parameter int SHARES = 2
) (
    input  logic                         ClkxCI,
    input  logic                         RstxBI,
    input  logic                         InValidxSI,
    output logic                         InReadyxSO,
    input  logic [4*SHARES-1:0]          _XxDI,
    input  logic [rnd_width(SHARES)-1:0] _Zmul1xDI,
    input  logic [rnd_width(SHARES)-1:0] _Zmul2xDI,
    input  logic [rnd_width(SHARES)-1:0] _Zmul3xDI,
    output logic                         OutValidxSO,
    input  logic                         OutReadyxSI,
    output logic [4*SHARES-1:0]          _QxDO
);

    logic                  en, clr1, clr2;
    logic                  v1_d, v1_q, v2_d, v2_q;
    logic [4*SHARES-1:0]   x_d, x_q;
    logic [2*SHARES-1:0]   a_in, b_in, a_s1, b_s1, e_s1, e_inv, ae_s2, be_s2;

    assign en          = ~v2_q | OutReadyxSI;
    assign InReadyxSO  = en;
    assign OutValidxSO = v2_q;

`ifdef MASKED_INV_BUBBLE_CLEAR_EN
    assign clr1 = ~InValidxSI;
    assign clr2 = ~v1_q;
`else
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
`endif

    // valid pipeline and A/B share delay, all frozen while the output is stalled
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        x_d  = x_q;
        if (en) begin
            v1_d = InValidxSI;
            v2_d = v1_q;
            x_d  = clr1 ? '0 : _XxDI;
        end
    end

    // pipeline registers
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            x_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            x_q  <= x_d;
        end
    end

    // share slicing, share-wise GF(2^2) inversion of E, output packing
    always_comb begin
        a_in  = '0;
        b_in  = '0;
        a_s1  = '0;
        b_s1  = '0;
        e_inv = '0;
        _QxDO = '0;
        for (int i = 0; i < SHARES; i++) begin
            a_in[2*i +: 2]  = nib_hi(_XxDI[4*i +: 4]);
            b_in[2*i +: 2]  = nib_lo(_XxDI[4*i +: 4]);
            a_s1[2*i +: 2]  = nib_hi(x_q[4*i +: 4]);
            b_s1[2*i +: 2]  = nib_lo(x_q[4*i +: 4]);
            e_inv[2*i +: 2] = gf4_sq(e_s1[2*i +: 2]);
            _QxDO[4*i +: 4] = {be_s2[2*i +: 2], ae_s2[2*i +: 2]};
        end
    end

    dom_gf4_mul_en #(.SHARES(SHARES), .SQSC(1'b1)) u_mul_e (
        .clk(ClkxCI), .rst_n(RstxBI), .en(en), .clr(clr1),
        .x(a_in), .y(b_in), .z(_Zmul1xDI), .q(e_s1)
    );

    dom_gf4_mul_en #(.SHARES(SHARES), .SQSC(1'b0)) u_mul_ae (
        .clk(ClkxCI), .rst_n(RstxBI), .en(en), .clr(clr2),
        .x(a_s1), .y(e_inv), .z(_Zmul2xDI), .q(ae_s2)
    );

    dom_gf4_mul_en #(.SHARES(SHARES), .SQSC(1'b0)) u_mul_be (
        .clk(ClkxCI), .rst_n(RstxBI), .en(en), .clr(clr2),
        .x(b_s1), .y(e_inv), .z(_Zmul3xDI), .q(be_s2)
    );

endmodule
